// File: rtl/mips32_loader_ctrl_if.sv
// mips32_loader_ctrl_if: session control, load stream, memory port, core control and result beats.
interface mips32_loader_ctrl_if #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10,
   parameter int NUM_CHK = 4
);
   localparam int IDX_W = NUM_CHK > 1 ? $clog2(NUM_CHK) : 1;
   logic              start;
   logic              ld_valid;
   logic              ld_ready;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic [ADDR_W-1:0] chk_base;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              core_run;
   logic              core_halted;
   logic              res_valid;
   logic [IDX_W-1:0]  res_idx;
   logic [DATA_W-1:0] res_data;
   logic              busy;
   logic              done;
   logic              timeout;
   logic [ADDR_W:0]   load_cnt;
   modport master (
      input  start, ld_valid, ld_data, ld_last, chk_base, mem_rdata, core_halted,
      output ld_ready, mem_we, mem_addr, mem_wdata, core_run, res_valid, res_idx, res_data,
             busy, done, timeout, load_cnt
   );
   modport slave (
      output start, ld_valid, ld_data, ld_last, chk_base, mem_rdata, core_halted,
      input  ld_ready, mem_we, mem_addr, mem_wdata, core_run, res_valid, res_idx, res_data,
             busy, done, timeout, load_cnt
   );
endinterface

// File: rtl/mips32_loader_ctrl.sv
// mips32_loader_ctrl: loads a program into memory, releases the core, then reads back result words.
// Optional run-phase watchdog is built when MIPS_LOADER_TIMEOUT_EN is defined.
module mips32_loader_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 10,
   parameter int PROG_DEPTH  = 256,
   parameter int NUM_CHK     = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input logic                  clk1,
   input logic                  rst_n,
   mips32_loader_ctrl_if.master bus
);
   localparam int IDX_W = NUM_CHK > 1 ? $clog2(NUM_CHK) : 1;
   localparam int CNT_W = $clog2(NUM_CHK + 1);
   localparam logic [ADDR_W:0] LOAD_MAX = (ADDR_W + 1)'(PROG_DEPTH - 1);
   if (PROG_DEPTH < 2 || PROG_DEPTH > 2 ** ADDR_W) begin : g_bad_depth
      $error("PROG_DEPTH out of range");
   end
   if (NUM_CHK < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("NUM_CHK and TIMEOUT_CYC must be at least 1");
   end
   if ($bits(bus.ld_data) != DATA_W || $bits(bus.res_idx) != IDX_W) begin : g_bad_bus
      $error("interface parameters do not match the controller");
   end
   typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, DONE} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W:0]   load_cnt_q, load_cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic              res_valid_q, res_valid_d;
   logic [IDX_W-1:0]  res_idx_q, res_idx_d;
   logic              start_ok, accept, issue, to_hit;
   assign start_ok = (state_q == IDLE || state_q == DONE) && bus.start;
   assign accept   = state_q == LOAD && bus.ld_valid;
   assign issue    = state_q == DUMP && rd_cnt_q != CNT_W'(NUM_CHK);
`ifdef MIPS_LOADER_TIMEOUT_EN
   localparam int RUN_W = $clog2(TIMEOUT_CYC + 1);
   logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
   logic             timeout_q, timeout_d;
   assign run_cnt_d = state_q == RUN ? run_cnt_q + 1'b1 : '0;
   assign to_hit    = state_q == RUN && run_cnt_q == RUN_W'(TIMEOUT_CYC - 1);
   // a halt seen in the same cycle as the limit is a normal finish
   assign timeout_d = start_ok ? 1'b0 : timeout_q | (to_hit && !bus.core_halted);
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         run_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         run_cnt_q <= run_cnt_d;
         timeout_q <= timeout_d;
      end
   end
   assign bus.timeout = timeout_q;
`else
   assign to_hit      = 1'b0;
   assign bus.timeout = 1'b0;
`endif
   always_comb begin
      state_d     = state_q;
      load_cnt_d  = load_cnt_q;
      base_d      = base_q;
      rd_cnt_d    = rd_cnt_q;
      res_valid_d = issue;
      res_idx_d   = issue ? IDX_W'(rd_cnt_q) : '0;
      case (state_q)
         IDLE, DONE: if (start_ok) begin
            state_d    = LOAD;
            load_cnt_d = '0;
            base_d     = bus.chk_base;
         end
         LOAD: if (accept) begin
            load_cnt_d = load_cnt_q + 1'b1;
            state_d    = bus.ld_last || load_cnt_q == LOAD_MAX ? RUN : LOAD;
         end
         RUN: begin
            rd_cnt_d = '0;
            state_d  = bus.core_halted || to_hit ? DUMP : RUN;
         end
         DUMP: begin
            rd_cnt_d = issue ? rd_cnt_q + 1'b1 : rd_cnt_q;
            state_d  = issue ? DUMP : DONE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         load_cnt_q  <= '0;
         base_q      <= '0;
         rd_cnt_q    <= '0;
         res_valid_q <= 1'b0;
         res_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         base_q      <= base_d;
         rd_cnt_q    <= rd_cnt_d;
         res_valid_q <= res_valid_d;
         res_idx_q   <= res_idx_d;
      end
   end
   // the address sum wraps naturally at ADDR_W bits
   assign bus.mem_addr  = accept ? load_cnt_q[ADDR_W-1:0] : issue ? base_q + ADDR_W'(rd_cnt_q) : '0;
   assign bus.mem_we    = accept;
   assign bus.mem_wdata = accept ? bus.ld_data : '0;
   assign bus.ld_ready  = state_q == LOAD;
   assign bus.core_run  = state_q == RUN;
   assign bus.res_valid = res_valid_q;
   assign bus.res_idx   = res_idx_q;
   assign bus.res_data  = res_valid_q ? bus.mem_rdata : '0;
   assign bus.busy      = state_q == LOAD || state_q == RUN || state_q == DUMP;
   assign bus.done      = state_q == DONE;
   assign bus.load_cnt  = load_cnt_q;
endmodule

// File: tb/tb_mips32_loader_ctrl.sv
// tb_mips32_loader_ctrl: directed checks of load, run, dump, depth limit, address wrap and reset.
// Instance a: 16-word program, 3 results; instance b: 4-word depth, 4 results, 20-cycle watchdog.
module tb_mips32_loader_ctrl;
   logic clk1 = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk1 = ~clk1;
   int cyc = 0;
   always @(posedge clk1) cyc <= cyc + 1;
   int n_chk = 0;
   int n_err = 0;
   mips32_loader_ctrl_if #(.DATA_W(32), .ADDR_W(10), .NUM_CHK(3)) ia ();
   mips32_loader_ctrl_if #(.DATA_W(32), .ADDR_W(10), .NUM_CHK(4)) ib ();
   mips32_loader_ctrl #(.PROG_DEPTH(16), .NUM_CHK(3)) u_a (.clk1(clk1), .rst_n(rst_n), .bus(ia.master));
   mips32_loader_ctrl #(.PROG_DEPTH(4), .NUM_CHK(4), .TIMEOUT_CYC(20)) u_b (.clk1(clk1), .rst_n(rst_n), .bus(ib.master));
   logic [31:0] mem_a [1024];
   logic [31:0] mem_b [1024];
   int run_a = 0, run_b = 0, halt_at_a = 60, halt_at_b = 5;
   logic force_halt_b = 1'b0;
   assign ia.core_halted = ia.core_run && run_a == halt_at_a;
   assign ib.core_halted = force_halt_b || (ib.core_run && run_b == halt_at_b);
   // memories with one-cycle read latency; the core model leaves its results on halt
   always @(posedge clk1) begin
      run_a <= ia.core_run ? run_a + 1 : 0;
      run_b <= ib.core_run ? run_b + 1 : 0;
      if (ia.mem_we) mem_a[ia.mem_addr] <= ia.mem_wdata;
      if (ia.core_halted) begin
         mem_a[198] <= 32'd5040;
         mem_a[199] <= 32'd99;
         mem_a[200] <= 32'd7;
      end
      ia.mem_rdata <= mem_a[ia.mem_addr];
      if (ib.mem_we) mem_b[ib.mem_addr] <= ib.mem_wdata;
      if (!rst_n) begin
         mem_b[1022] <= 32'hAAAA_0001;
         mem_b[1023] <= 32'hBBBB_0002;
      end
      ib.mem_rdata <= mem_b[ib.mem_addr];
   end
   logic [31:0] wa_addr[$], wa_data[$], ra_idx[$], ra_data[$];
   logic [31:0] wb_addr[$], wb_data[$], rb_data[$], rb_addr[$];
   int ra_cyc[$];
   always @(negedge clk1) begin
      if (ia.mem_we) begin
         wa_addr.push_back(32'(ia.mem_addr));
         wa_data.push_back(ia.mem_wdata);
      end
      if (ia.res_valid) begin
         ra_idx.push_back(32'(ia.res_idx));
         ra_data.push_back(ia.res_data);
         ra_cyc.push_back(cyc);
      end
      if (ib.mem_we) begin
         wb_addr.push_back(32'(ib.mem_addr));
         wb_data.push_back(ib.mem_wdata);
      end
      if (ib.res_valid) rb_data.push_back(ib.res_data);
      if (ib.busy && !ib.ld_ready && !ib.core_run) rb_addr.push_back(32'(ib.mem_addr));
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk1);
      #1;
   endtask
   task automatic pulse_start(input bit s, input logic [9:0] base);
      if (s) begin ib.start = 1'b1; ib.chk_base = base; end
      else begin ia.start = 1'b1; ia.chk_base = base; end
      step();
      ia.start = 1'b0;
      ib.start = 1'b0;
   endtask
   task automatic load(input bit s, input int n, input int last_k, input logic [31:0] seed);
      for (int k = 0; k < n; k++) begin
         if (s) begin ib.ld_valid = 1'b1; ib.ld_data = seed + 32'(k); ib.ld_last = k == last_k; end
         else begin ia.ld_valid = 1'b1; ia.ld_data = seed + 32'(k); ia.ld_last = k == last_k; end
         step();
      end
      ia.ld_valid = 1'b0; ia.ld_last = 1'b0;
      ib.ld_valid = 1'b0; ib.ld_last = 1'b0;
   endtask
   task automatic wait_done(input bit s, input int budget, input string tag);
      int k = 0;
      while (!(s ? ib.done : ia.done) && k < budget) begin
         step();
         k++;
      end
      check(tag, s ? ib.done : ia.done, 1'b1);
   endtask
   task automatic check_quiet(input string tag);
      check({tag, "_a"}, |{ia.ld_ready, ia.mem_we, ia.mem_addr, ia.mem_wdata, ia.core_run, ia.res_valid,
                          ia.res_idx, ia.res_data, ia.busy, ia.done, ia.timeout, ia.load_cnt}, 1'b0);
      check({tag, "_b"}, |{ib.ld_ready, ib.mem_we, ib.mem_addr, ib.mem_wdata, ib.core_run, ib.res_valid,
                          ib.res_idx, ib.res_data, ib.busy, ib.done, ib.timeout, ib.load_cnt}, 1'b0);
   endtask
   logic rdy [6];
   int run_len, n_w;
   initial begin
      ia.start = 1'b0; ia.ld_valid = 1'b0; ia.ld_data = '0; ia.ld_last = 1'b0; ia.chk_base = '0;
      ib.start = 1'b0; ib.ld_valid = 1'b0; ib.ld_data = '0; ib.ld_last = 1'b0; ib.chk_base = '0;
      repeat (3) step();
      check_quiet("reset");
      rst_n = 1'b1;
      step();
      // factorial session on instance a
      pulse_start(0, 10'd198);
      check("a_busy_load", {ia.busy, ia.ld_ready}, 2'b11);
      load(0, 11, 10, 32'h1000);
      check("a_load_cnt", ia.load_cnt, 11);
      check("a_run", {ia.core_run, ia.ld_ready}, 2'b10);
      check("a_writes", wa_addr.size(), 11);
      if (wa_addr.size() == 11) begin
         check("a_w0", {wa_addr[0], wa_data[0]}, {32'd0, 32'h1000});
         check("a_w10", {wa_addr[10], wa_data[10]}, {32'd10, 32'h100A});
      end
      wait_done(0, 200, "a_done");
      check("a_nres", ra_data.size(), 3);
      if (ra_data.size() == 3) begin
         check("a_res0", {ra_idx[0], ra_data[0]}, {32'd0, 32'd5040});
         check("a_res1", {ra_idx[1], ra_data[1]}, {32'd1, 32'd99});
         check("a_res2", {ra_idx[2], ra_data[2]}, {32'd2, 32'd7});
         check("a_b2b", ra_cyc[2] - ra_cyc[0], 2);
      end
      check("a_no_to", ia.timeout, 1'b0);
      repeat (3) step();
      check("a_done_hold", {ia.done, ia.busy}, 2'b10);
      // depth limit and address wrap on instance b; halt is ignored while loading
      force_halt_b = 1'b1;
      pulse_start(1, 10'd1022);
      for (int k = 0; k < 6; k++) begin
         ib.ld_valid = 1'b1;
         ib.ld_data = 32'h100 + 32'(k);
         ib.ld_last = 1'b0;
         if (k == 2) force_halt_b = 1'b0;
         rdy[k] = ib.ld_ready;
         step();
      end
      ib.ld_valid = 1'b0;
      check("b_nwrites", wb_addr.size(), 4);
      if (wb_addr.size() == 4) check("b_w3", {wb_addr[3], wb_data[3]}, {32'd3, 32'h103});
      check("b_rdy", {rdy[0], rdy[3], rdy[4], rdy[5]}, 4'b1100);
      check("b_load_cnt", ib.load_cnt, 4);
      check("b_run", {ib.core_run, ib.busy}, 2'b11);
      wait_done(1, 100, "b_done");
      if (rb_addr.size() >= 4) check("b_wrap_addr", {rb_addr[0], rb_addr[1], rb_addr[2], rb_addr[3]},
                                     {32'd1022, 32'd1023, 32'd0, 32'd1});
      else check("b_nreads", rb_addr.size(), 4);
      check("b_nres", rb_data.size(), 4);
      if (rb_data.size() == 4) check("b_wrap_data", {rb_data[0], rb_data[1], rb_data[2], rb_data[3]},
                                     {32'hAAAA_0001, 32'hBBBB_0002, 32'h100, 32'h101});
`ifdef MIPS_LOADER_TIMEOUT_EN
      halt_at_b = 1000;
      rb_data.delete();
      pulse_start(1, 10'd1022);
      load(1, 2, 1, 32'h400);
      run_len = 0;
      while (ib.core_run && run_len < 100) begin
         step();
         run_len++;
      end
      check("to_run_len", run_len, 20);
      check("to_flag", ib.timeout, 1'b1);
      wait_done(1, 50, "to_done");
      check("to_nres", rb_data.size(), 4);
      check("to_sticky", ib.timeout, 1'b1);
      halt_at_b = 19;
      pulse_start(1, 10'd1022);
      check("to_clear", ib.timeout, 1'b0);
      load(1, 2, 1, 32'h500);
      run_len = 0;
      while (ib.core_run && run_len < 100) begin
         step();
         run_len++;
      end
      check("tie_run_len", run_len, 20);
      check("tie_no_to", ib.timeout, 1'b0);
      wait_done(1, 50, "tie_done");
`else
      halt_at_b = 1000;
      pulse_start(1, 10'd1022);
      load(1, 2, 1, 32'h400);
      repeat (100) step();
      check("nto_wait", {ib.core_run, ib.timeout}, 2'b10);
`endif
      // reset mid-load, then restart
      pulse_start(0, 10'd198);
      check("r_start_clr", {ia.done, ia.load_cnt}, 12'd0);
      load(0, 3, 99, 32'h200);
      n_w = wa_addr.size();
      rst_n = 1'b0;
      step();
      check_quiet("mid_reset");
      step();
      check("r_no_write", wa_addr.size(), n_w);
      rst_n = 1'b1;
      halt_at_a = 10;
      ra_data.delete();
      ra_idx.delete();
      pulse_start(0, 10'd198);
      load(0, 11, 10, 32'h300);
      if (wa_addr.size() > n_w) check("r_addr0", {wa_addr[n_w], wa_data[n_w]}, {32'd0, 32'h300});
      else check("r_nwrites", wa_addr.size(), n_w + 11);
      pulse_start(0, 10'd5);
      check("r_start_in_run", {ia.core_run, ia.load_cnt}, {1'b1, 11'd11});
      wait_done(0, 100, "r_done");
      if (ra_data.size() == 3) check("r_base_kept", ra_data[0], 32'd5040);
      else check("r_nres", ra_data.size(), 3);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mips32_loader_ctrl.md
MIPS32_LOADER_CTRL -- requirements
Module: mips32_loader_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, memory word width.
REQ-002 Parameter ADDR_W, default 10, memory address width.
REQ-003 Parameter PROG_DEPTH, default 256, maximum program words loaded; 2 <= PROG_DEPTH <= 2^ADDR_W.
REQ-004 Parameter NUM_CHK, default 4, result words read back after halt; at least 1.
REQ-005 Parameter TIMEOUT_CYC, default 4096, run-phase cycle limit; at least 1.
REQ-006 Ports SHALL be, clock and reset first:
- clk1  in  1  sole clock, rising edge; no second phase.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a session.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  load word accepted.
- ld_data  in  DATA_W  program word.
- ld_last  in  1  final program word.
- chk_base  in  ADDR_W  first result address; sampled on start.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  read data, valid one cycle after mem_addr.
- core_run  out  1  releases the core; low holds it stopped with PC at 0.
- core_halted  in  1  core HALTED flag.
- res_valid  out  1  result word valid.
- res_idx  out  clog2(NUM_CHK), minimum 1  result index.
- res_data  out  DATA_W  result word.
- busy  out  1  session in progress.
- done  out  1  session complete.
- timeout  out  1  sticky run-timeout flag.
- load_cnt  out  ADDR_W+1  words loaded this session.

Function
REQ-007 State machine SHALL have states IDLE, LOAD, RUN, DUMP and DONE; busy = 1 in LOAD, RUN and DUMP.
REQ-008 IDLE/DONE + start -> LOAD: clear load_cnt, timeout and done; capture chk_base.
REQ-009 start in LOAD, RUN or DUMP SHALL be ignored.
REQ-010 LOAD: ld_ready = 1; each ld_valid&ld_ready cycle drives mem_we = 1, mem_addr = load_cnt, mem_wdata = ld_data in the same cycle; load_cnt increments.
REQ-011 LOAD exits to RUN after the accepting cycle when ld_last = 1 or load_cnt reaches PROG_DEPTH-1; ld_ready drops the next cycle; excess words are never accepted.
REQ-012 RUN: core_run = 1 from the first RUN cycle; core_halted SHALL be ignored outside RUN.
REQ-013 RUN -> DUMP on the first cycle core_halted = 1; core_run drops in DUMP.
REQ-014 DUMP: issues reads at chk_base+i for i = 0..NUM_CHK-1, one per cycle; the sum wraps modulo 2^ADDR_W.
REQ-015 One cycle after each read: res_valid = 1, res_idx = i, res_data = mem_rdata; outputs are back-to-back, no gaps.
REQ-016 DUMP -> DONE the cycle after the last result; DONE holds done = 1 until the next start.
REQ-017 mem_we SHALL be 0 in every state except LOAD.

Reset
REQ-018 With rst_n = 0 at a clk1 edge: state = IDLE and every output = 0, including ld_ready, core_run, res_* and load_cnt.
REQ-019 Reset mid-session SHALL abort immediately, with no further memory writes or result beats.

Configuration
REQ-020 Macro MIPS_LOADER_TIMEOUT_EN defined:
- a run counter clears on RUN entry and counts RUN cycles.
- when it reaches TIMEOUT_CYC, the block sets timeout = 1 and moves to DUMP, so results are still read.
- if core_halted and the limit occur in the same cycle, halt wins and timeout stays 0.
REQ-021 Macro MIPS_LOADER_TIMEOUT_EN undefined: no counter is built, timeout is tied to 0 and RUN waits indefinitely.

Verification
REQ-022 Factorial test:
- stimulus: load 11 words with ld_last on word 10; the core model halts 60 cycles after core_run and leaves mem[198] = 5040, mem[200] = 7; chk_base = 198, NUM_CHK = 3.
- required response: load_cnt = 11; results idx0 = 5040 and idx2 = 7 on consecutive cycles; then done = 1.
REQ-023 Depth limit:
- stimulus: PROG_DEPTH = 4; stream 6 words with no ld_last.
- required response: exactly 4 writes, to addresses 0..3; ld_ready = 0 from the 5th word onward; state = RUN.
REQ-024 Timeout, macro defined:
- stimulus: TIMEOUT_CYC = 20; core_halted never asserts.
- required response: core_run drops after 20 RUN cycles; timeout = 1; NUM_CHK results follow; then done = 1.
REQ-025 Address wrap:
- stimulus: ADDR_W = 10, chk_base = 1022, NUM_CHK = 4.
- required response: reads at 1022, 1023, 0, 1.
REQ-026 Reset and restart:
- stimulus: rst_n = 0 mid-LOAD after 3 words, then a new start.
- required response: all outputs 0 after reset; the new session writes from address 0 again; start pulses during RUN have no effect.
